srl_dly_ctrl: RTL and testbench
===============================

# srl_dly_ctrl

Sequencing controller for the SRL16E parallel delay-line bank used on the RPC/CLCT raw-data paths. It owns the shared address bus and clock-enable of the bank. It tracks how many enabled shifts have occurred since reset or flush, so it knows when the tap selected by the address holds real data. It applies run-time delay changes with a blanking window and reports output validity to downstream logic.

## Interface
Parameters:
- DLY_RST, 0: delay (tap address) loaded at reset, 0–15.
- BLANK_CYC, 1: cycles q_vld is forced low after an applied delay change, 1–15.

Ports:
- clock  in  1  fabric clock, shared with the SRL bank.
- reset  in  1  synchronous, active-high.
- run_en  in  1  request to shift the bank this cycle.
- flush  in  1  one-cycle strobe; declares bank contents stale.
- dly_wr  in  1  one-cycle strobe; load dly_set.
- dly_set  in  4  requested delay.
- adr  out  4  tap address to all SRLs; registered.
- ce  out  1  shift enable to all SRLs; ce = run_en & ~reset, combinational.
- q_vld  out  1  bank output q is valid data; registered.
- dly_chg  out  1  one-cycle pulse, coincident with the first cycle of a new adr.
- busy  out  1  high whenever state ≠ RUN.

## Operation
- Counter fill_cnt, 5 bits.
  - Increments on every edge where ce=1.
  - Saturates at 16.
  - Cleared by reset or flush.
  - flush has priority over the increment in the same cycle.
- A tap A is filled when fill_cnt ≥ A+1. The SRL output at address A equals the d value presented A+1 enabled edges earlier.
- Blank counter bcnt, 4 bits. Loaded with BLANK_CYC when a delay change is applied; decrements to 0.
- States:
  - FILL: tap not filled. → BLANK if bcnt≠0 once filled. → RUN if bcnt=0 once filled.
  - BLANK: bcnt≠0 and tap filled. → RUN when bcnt reaches 0 and tap filled. → FILL if flush.
  - RUN: tap filled, bcnt=0. → BLANK on an applied delay change. → FILL on flush. → FILL on a change to an unfilled tap.
- Delay change, dly_wr=1:
  - If dly_set ≠ adr: adr ← dly_set, dly_chg=1, bcnt ← BLANK_CYC. Applied from any state.
  - If dly_set = adr: no action, no dly_chg pulse.
  - A dly_wr during BLANK restarts bcnt.
- q_vld = 1 iff next state is RUN. It is computed from next-cycle fill_cnt, adr and bcnt, so it aligns with the q seen in the same cycle as the new adr.
- run_en low holds fill_cnt, bcnt still counts down, and q_vld keeps its level. Downstream qualifies new samples with ce.
- flush and dly_wr in the same cycle: both take effect. adr updates, dly_chg pulses, fill_cnt=0, state → FILL.
- Reset, including mid-operation, forces all outputs and state to their reset values; flush and dly_wr are ignored while reset is high.

## Timing
- Reset values: adr=DLY_RST, ce=0, q_vld=0, dly_chg=0, busy=1, fill_cnt=0, bcnt=0, state=FILL.
- Edge k denotes the k-th rising edge after reset deasserts.
- With run_en=1 continuously from edge 1 and adr=A:
  - q_vld rises on edge A+1.
  - busy falls on the same edge.
- dly_wr at cycle t, with a changed value and the new tap already filled:
  - adr, dly_chg and q_vld=0 all appear after edge t+1.
  - q_vld returns after edge t+1+BLANK_CYC.
- If the new tap is not yet filled, q_vld returns at the later of:
  - tap filled;
  - blank expired.
- Latency from flush to q_vld=0 is one edge.
- No combinational path from any input to q_vld, adr or dly_chg.

## Test plan
1. DLY_RST=0; deassert reset, run_en=1 → q_vld=1 after edge 1, busy=0; feed ramp d=1,2,3… and check q equals d one edge late.
2. dly_wr with dly_set=5 at cycle 0 after reset, run_en=1 → adr=5 after edge 1, q_vld rises after edge 6, and q lags d by 6.
3. adr=5, run_en low for 3 cycles after edge 3 of the fill → q_vld rises 3 cycles later than in scenario 2, i.e. on the 6th ce edge.
4. Steady RUN at adr=5 with fill_cnt=16; dly_wr with dly_set=10, BLANK_CYC=2 → one dly_chg pulse, q_vld low for exactly 2 cycles, q lags d by 11. dly_wr with dly_set=10 again → no pulse, q_vld stays high.
5. flush and dly_wr (dly_set=3) in the same cycle during RUN → adr=3, dly_chg pulses, q_vld low for 4 ce edges then high.
6. Reset asserted for 1 cycle mid-FILL at adr=7 → next cycle adr=DLY_RST, q_vld=0, busy=1; fill restarts from 0.

Source files
------------

// File: rtl/srl_dly_ctrl.sv
// srl_dly_ctrl: sequences the shared address and clock enable of an SRL16E delay-line bank, tracks fill depth, blanks the output after delay changes and flags when the tap output is valid.
module srl_dly_ctrl #(
  parameter int DLY_RST   = 0,
  parameter int BLANK_CYC = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run_en,
  input  logic       flush,
  input  logic       dly_wr,
  input  logic [3:0] dly_set,
  output logic [3:0] adr,
  output logic       ce,
  output logic       q_vld,
  output logic       dly_chg,
  output logic       busy
);
  typedef enum logic [1:0] {FILL, BLANK, RUN} state_t;
  state_t     state, state_nxt;
  logic [4:0] fill_cnt, fill_nxt;
  logic [3:0] bcnt, bcnt_nxt, adr_nxt;
  logic       chg;
  assign ce   = run_en & ~reset;
  assign busy = state != RUN;
  // Everything is judged on next-cycle values so q_vld lines up with the first q read at the new adr.
  always_comb begin
    chg       = dly_wr && (dly_set != adr);
    adr_nxt   = chg ? dly_set : adr;
    fill_nxt  = flush ? 5'd0 : (ce && fill_cnt != 5'd16) ? fill_cnt + 5'd1 : fill_cnt;
    bcnt_nxt  = chg ? 4'(BLANK_CYC) : (bcnt != 4'd0) ? bcnt - 4'd1 : 4'd0;
    state_nxt = (fill_nxt <= {1'b0, adr_nxt}) ? FILL : (bcnt_nxt != 4'd0) ? BLANK : RUN;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      adr      <= 4'(DLY_RST);
      fill_cnt <= 5'd0;
      bcnt     <= 4'd0;
      state    <= FILL;
      q_vld    <= 1'b0;
      dly_chg  <= 1'b0;
    end else begin
      adr      <= adr_nxt;
      fill_cnt <= fill_nxt;
      bcnt     <= bcnt_nxt;
      state    <= state_nxt;
      q_vld    <= state_nxt == RUN;
      dly_chg  <= chg;
    end
  end
endmodule

// File: tb/tb_srl_dly_ctrl.sv
// tb_srl_dly_ctrl: directed bench for srl_dly_ctrl with a behavioural SRL16 bank fed by a ramp.
module tb_srl_dly_ctrl;
  logic       clock = 1'b0;
  logic       reset, run_en, flush, dly_wr;
  logic [3:0] dly_set, adr;
  logic       ce, q_vld, dly_chg, busy;
  logic [7:0] d = 8'd0;
  logic [7:0] sr [16];
  logic [7:0] q;
  int total = 0;
  int bad = 0;

  srl_dly_ctrl #(.DLY_RST(0), .BLANK_CYC(2)) dut (
    .clock(clock), .reset(reset), .run_en(run_en), .flush(flush), .dly_wr(dly_wr),
    .dly_set(dly_set), .adr(adr), .ce(ce), .q_vld(q_vld), .dly_chg(dly_chg), .busy(busy)
  );

  always #5 clock = ~clock;

  // Bank model: every enabled edge shifts the current ramp value in and advances the ramp.
  always @(posedge clock) if (ce) begin
    for (int i = 15; i > 0; i--) sr[i] <= sr[i-1];
    sr[0] <= d;
    d <= d + 8'd1;
  end
  assign q = sr[adr];

  task tick();
    @(posedge clock);
    #1;
  endtask

  task test_reset();
    reset = 1; run_en = 1; flush = 0; dly_wr = 0; dly_set = 0;
    tick(); tick();
    total++; if (ce !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b exp=0", ce); end
    total++; if (adr !== 4'd0) begin bad++; $display("FAIL reset_adr got=%0d exp=0", adr); end
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL reset_qvld got=%b exp=0", q_vld); end
    total++; if (dly_chg !== 1'b0) begin bad++; $display("FAIL reset_chg got=%b exp=0", dly_chg); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
  endtask

  task test_fill0();
    reset = 0;
    tick();
    total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL fill0_qvld got=%b exp=1", q_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fill0_busy got=%b exp=0", busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL fill0_hold k=%0d got=%b exp=1", k, q_vld); end
      total++; if (q !== d - 8'd1) begin bad++; $display("FAIL fill0_q k=%0d got=%0d exp=%0d", k, q, d - 8'd1); end
    end
  endtask

  task test_dly5();
    reset = 1; tick();
    reset = 0; dly_wr = 1; dly_set = 5;
    tick();
    dly_wr = 0;
    total++; if (adr !== 4'd5) begin bad++; $display("FAIL dly5_adr got=%0d exp=5", adr); end
    total++; if (dly_chg !== 1'b1) begin bad++; $display("FAIL dly5_chg got=%b exp=1", dly_chg); end
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL dly5_qvld1 got=%b exp=0", q_vld); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL dly5_early edge=%0d got=%b exp=0", k, q_vld); end
    end
    total++; if (dly_chg !== 1'b0) begin bad++; $display("FAIL dly5_chg_once got=%b exp=0", dly_chg); end
    tick();
    total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL dly5_qvld6 got=%b exp=1", q_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dly5_busy got=%b exp=0", busy); end
    total++; if (q !== d - 8'd6) begin bad++; $display("FAIL dly5_q got=%0d exp=%0d", q, d - 8'd6); end
  endtask

  task test_stall();
    reset = 1; tick();
    reset = 0; dly_wr = 1; dly_set = 5;
    tick();
    dly_wr = 0;
    tick(); tick();
    run_en = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL stall_hold k=%0d got=%b exp=0", k, q_vld); end
    end
    run_en = 1;
    tick(); tick();
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL stall_ce5 got=%b exp=0", q_vld); end
    tick();
    total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL stall_ce6 got=%b exp=1", q_vld); end
  endtask

  task test_change();
    repeat (12) tick();
    total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL chg_steady got=%b exp=1", q_vld); end
    dly_wr = 1; dly_set = 10;
    tick();
    dly_wr = 0;
    total++; if (adr !== 4'd10) begin bad++; $display("FAIL chg_adr got=%0d exp=10", adr); end
    total++; if (dly_chg !== 1'b1) begin bad++; $display("FAIL chg_pulse got=%b exp=1", dly_chg); end
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL chg_blank1 got=%b exp=0", q_vld); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL chg_busy got=%b exp=1", busy); end
    tick();
    total++; if (dly_chg !== 1'b0) begin bad++; $display("FAIL chg_pulse_end got=%b exp=0", dly_chg); end
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL chg_blank2 got=%b exp=0", q_vld); end
    tick();
    total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL chg_back got=%b exp=1", q_vld); end
    total++; if (q !== d - 8'd11) begin bad++; $display("FAIL chg_q got=%0d exp=%0d", q, d - 8'd11); end
    dly_wr = 1; dly_set = 10;
    tick();
    dly_wr = 0;
    total++; if (dly_chg !== 1'b0) begin bad++; $display("FAIL same_pulse got=%b exp=0", dly_chg); end
    total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL same_qvld got=%b exp=1", q_vld); end
  endtask

  task test_flush_chg();
    flush = 1; dly_wr = 1; dly_set = 3;
    tick();
    flush = 0; dly_wr = 0;
    total++; if (adr !== 4'd3) begin bad++; $display("FAIL fc_adr got=%0d exp=3", adr); end
    total++; if (dly_chg !== 1'b1) begin bad++; $display("FAIL fc_pulse got=%b exp=1", dly_chg); end
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL fc_qvld0 got=%b exp=0", q_vld); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL fc_low ce=%0d got=%b exp=0", k, q_vld); end
    end
    tick();
    total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL fc_high got=%b exp=1", q_vld); end
    total++; if (q !== d - 8'd4) begin bad++; $display("FAIL fc_q got=%0d exp=%0d", q, d - 8'd4); end
  endtask

  task test_flush_lat();
    flush = 1;
    tick();
    flush = 0;
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL fl_qvld got=%b exp=0", q_vld); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fl_busy got=%b exp=1", busy); end
    total++; if (adr !== 4'd3) begin bad++; $display("FAIL fl_adr got=%0d exp=3", adr); end
    total++; if (dly_chg !== 1'b0) begin bad++; $display("FAIL fl_chg got=%b exp=0", dly_chg); end
  endtask

  task test_reset_mid();
    reset = 1; tick();
    reset = 0; dly_wr = 1; dly_set = 7;
    tick();
    dly_wr = 0;
    tick(); tick();
    total++; if (adr !== 4'd7) begin bad++; $display("FAIL rm_adr7 got=%0d exp=7", adr); end
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL rm_fill got=%b exp=0", q_vld); end
    reset = 1; flush = 1; dly_wr = 1; dly_set = 9;
    tick();
    total++; if (ce !== 1'b0) begin bad++; $display("FAIL rm_ce got=%b exp=0", ce); end
    total++; if (adr !== 4'd0) begin bad++; $display("FAIL rm_adr got=%0d exp=0", adr); end
    total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL rm_qvld got=%b exp=0", q_vld); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy got=%b exp=1", busy); end
    total++; if (dly_chg !== 1'b0) begin bad++; $display("FAIL rm_chg got=%b exp=0", dly_chg); end
    reset = 0; flush = 0; dly_wr = 0;
    tick();
    total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL rm_restart got=%b exp=1", q_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy2 got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_fill0();
    test_dly5();
    test_stall();
    test_change();
    test_flush_chg();
    test_flush_lat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
